// File: rtl/bus_arb8w32.sv
// ---------------------------------------------------------------------------
// bus_arb8w32 - round-robin arbiter for one shared 32-bit result path.
//
// Eight requesters compete for a single valid/ready output. In IDLE, the
// first set request bit at or after the rotating pointer wins. The winner's
// lane is registered onto the output and a one-cycle grant pulse is issued.
// The arbiter then waits in BUSY until the consumer accepts the word.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous, active-low reset
//   req        in   [7:0]        per-lane request, bit i = lane i
//   req_data   in   [8*WIDTH-1:0] lane i at [WIDTH*i +: WIDTH]
//   gnt        out  [7:0]        registered one-hot grant, one cycle wide
//   out_data   out  [WIDTH-1:0]  registered data of the granted lane
//   out_src    out  [2:0]        index of the lane owning out_data
//   out_valid  out               out_data / out_src valid
//   out_ready  in                consumer accepts the current transfer
//   busy       out               high while a transfer is outstanding
// ---------------------------------------------------------------------------

// 8:1 lane selector. It is purely combinational pass-through.
module mux8w32 (
  input  logic [255:0] in,
  input  logic [2:0]   sel,
  output logic [31:0]  out
);
  assign out = in[{sel, 5'd0} +: 32];
endmodule

module bus_arb8w32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] req_data,
  output logic [7:0]         gnt,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic        state;
  logic [2:0]  ptr;
  logic [2:0]  win_p0;
  logic [31:0] mux_data_p0;

  // Rotating-priority search. The loop runs from the farthest offset down
  // to offset 0, so the nearest set bit at or after ptr is the last match
  // and therefore the winner. The result is only used when req is non-zero.
  function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                         input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] i);
    return 8'b1 << i;
  endfunction

  assign win_p0 = rr_pick(req, ptr);

  mux8w32 u_mux (
    .in  (req_data),
    .sel (win_p0),
    .out (mux_data_p0)
  );

  assign busy = (state == ST_BUSY);

  // ---- stage boundary: arbitration result -> registered output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 3'd0;
    end else begin
      // The grant is a single-cycle pulse. It is raised only on the
      // arbitration edge below.
      gnt <= 8'd0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            out_data  <= mux_data_p0;
            out_src   <= win_p0;
            out_valid <= 1'b1;
            gnt       <= onehot8(win_p0);
            ptr       <= win_p0 + 3'd1;  // the winner drops to lowest priority
            state     <= ST_BUSY;
          end
        end
        default: begin
          // Requests are ignored here. Acceptance returns the FSM to IDLE
          // first, and new requests are arbitrated on the next edge.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb8w32.sv
// ---------------------------------------------------------------------------
// tb_bus_arb8w32 - directed, table-driven bench for bus_arb8w32.
// Lane i always carries 32'hA + i.
// ---------------------------------------------------------------------------
module tb_bus_arb8w32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   req;
  logic [255:0] req_data;
  logic [7:0]   gnt;
  logic [31:0]  out_data;
  logic [2:0]   out_src;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_arb8w32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0]  req;
    logic        rdy;
    logic [7:0]  gnt;
    logic        vld;
    logic [31:0] data;
    logic [2:0]  src;
    logic        busy;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] g, input logic v,
                         input logic [31:0] d, input logic [2:0] s,
                         input logic b);
    chk({nm, ".gnt"},       32'(gnt),       32'(g));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({nm, ".out_data"},  out_data,       d);
    chk({nm, ".out_src"},   32'(out_src),   32'(s));
    chk({nm, ".busy"},      32'(busy),      32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Full contention after the reset grant to lane 0: the handshake, then
    // the grant to lane g, for g = 1..8 (lane 8 wraps back to lane 0).
    for (int g = 1; g <= 8; g++) begin
      tbl[2*g-2] = '{req: 8'hFF, rdy: 1'b1, gnt: 8'h00, vld: 1'b0,
                     data: 32'hA + 32'(g-1), src: 3'(g-1), busy: 1'b0};
      tbl[2*g-1] = '{req: 8'hFF, rdy: 1'b1, gnt: 8'b1 << (g % 8), vld: 1'b1,
                     data: 32'hA + 32'(g % 8), src: 3'(g % 8), busy: 1'b1};
    end

    for (int i = 0; i < 8; i++) req_data[32*i +: 32] = 32'hA + 32'(i);
    rst_n = 1'b0; req = 8'h00; out_ready = 1'b0;

    // Reset state
    #3;
    chk_all("reset", 8'h00, 1'b0, 32'h0, 3'd0, 1'b0);
    #10; rst_n = 1'b1;                      // t=13, between edges

    // Single requester: lane 3
    req = 8'h08; out_ready = 1'b1;
    step();
    chk_all("single.grant", 8'h08, 1'b1, 32'hD, 3'd3, 1'b1);
    req = 8'h00;
    step();
    chk_all("single.after", 8'h00, 1'b0, 32'hD, 3'd3, 1'b0);

    // Reset mid-sim with all lanes requesting and the consumer stalled
    req = 8'hFF; out_ready = 1'b0;
    step();
    chk_all("pre_reset.grant", 8'h10, 1'b1, 32'hE, 3'd4, 1'b1);
    #2; rst_n = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 1'b0, 32'h0, 3'd0, 1'b0);
    #2; rst_n = 1'b1;
    step();
    chk_all("post_reset.grant", 8'h01, 1'b1, 32'hA, 3'd0, 1'b1);

    // Full contention, table-driven
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; out_ready = tbl[i].rdy;
      step();
      chk_all($sformatf("contend[%0d]", i), tbl[i].gnt, tbl[i].vld,
              tbl[i].data, tbl[i].src, tbl[i].busy);
    end

    // Backpressure: grant lane 2, then stall for 5 cycles with req = F0
    req = 8'h04; out_ready = 1'b1;
    step();
    chk_all("bp.hs0", 8'h00, 1'b0, 32'hA, 3'd0, 1'b0);
    out_ready = 1'b0;
    step();
    chk_all("bp.grant2", 8'h04, 1'b1, 32'hC, 3'd2, 1'b1);
    req = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("bp.stall[%0d]", i), 8'h00, 1'b1, 32'hC, 3'd2, 1'b1);
    end
    out_ready = 1'b1;
    step();
    chk_all("bp.hs", 8'h00, 1'b0, 32'hC, 3'd2, 1'b0);
    step();
    chk_all("bp.next", 8'h10, 1'b1, 32'hE, 3'd4, 1'b1);

    // Pointer wrap: lane 6, then req = 81 gives lane 7 and then lane 0
    req = 8'h40;
    step();
    chk_all("wrap.hs0", 8'h00, 1'b0, 32'hE, 3'd4, 1'b0);
    step();
    chk_all("wrap.g6", 8'h40, 1'b1, 32'h10, 3'd6, 1'b1);
    req = 8'h81;
    step();
    chk_all("wrap.hs1", 8'h00, 1'b0, 32'h10, 3'd6, 1'b0);
    step();
    chk_all("wrap.g7", 8'h80, 1'b1, 32'h11, 3'd7, 1'b1);
    step();
    chk_all("wrap.hs2", 8'h00, 1'b0, 32'h11, 3'd7, 1'b0);
    step();
    chk_all("wrap.g0", 8'h01, 1'b1, 32'hA, 3'd0, 1'b1);
    req = 8'h00;
    step();
    chk_all("wrap.hs3", 8'h00, 1'b0, 32'hA, 3'd0, 1'b0);

    // Reset mid-transfer: lane 3 is stalled, reset, then lane 4 alone
    req = 8'h08; out_ready = 1'b0;
    step();
    chk_all("rmt.grant3", 8'h08, 1'b1, 32'hD, 3'd3, 1'b1);
    req = 8'h10;
    #2; rst_n = 1'b0;
    #1;
    chk_all("rmt.reset", 8'h00, 1'b0, 32'h0, 3'd0, 1'b0);
    #2; rst_n = 1'b1;
    step();
    chk_all("rmt.grant4", 8'h10, 1'b1, 32'hE, 3'd4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
